// File: rtl/dlx_pkg.sv
// Shared definitions for the sized DLX memory-access stage: opcodes, access sizes,
// FSM states and the opcode decoder.
package dlx_pkg;

    localparam logic [5:0] OP_LB  = 6'b000001;
    localparam logic [5:0] OP_LBU = 6'b000010;
    localparam logic [5:0] OP_LH  = 6'b000011;
    localparam logic [5:0] OP_LHU = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b000101;
    localparam logic [5:0] OP_SB  = 6'b001000;
    localparam logic [5:0] OP_SH  = 6'b001001;
    localparam logic [5:0] OP_SW  = 6'b001010;

    localparam logic [31:0] NOP = 32'h0;

    // Wait-counter width; saturates rather than wrapping when the timeout is disabled.
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        logic      sign_ext;
        mem_size_e size;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t d;
        d.is_mem   = 1'b1;
        d.is_load  = 1'b0;
        d.sign_ext = 1'b0;
        d.size     = SZ_W;
        case (op)
            OP_LB:  begin d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SZ_B; end
            OP_LBU: begin d.is_load = 1'b1; d.size = SZ_B; end
            OP_LH:  begin d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SZ_H; end
            OP_LHU: begin d.is_load = 1'b1; d.size = SZ_H; end
            OP_LW:  begin d.is_load = 1'b1; d.size = SZ_W; end
            OP_SB:  d.size = SZ_B;
            OP_SH:  d.size = SZ_H;
            OP_SW:  d.size = SZ_W;
            default: d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering for sized accesses: byte enables, replicated store data,
// load lane extraction with sign/zero extension, and the alignment check.
module mem_lane_align
    import dlx_pkg::*;
(
    input  mem_size_e   size,
    input  logic        sign_ext,
    input  logic [1:0]  off,
    input  logic [31:0] bin4,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        aligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Byte offset 0 is the most significant lane.
    always_comb begin
        byte_lane = 8'h00;
        case (off)
            2'd0: byte_lane = mem_rdata[31:24];
            2'd1: byte_lane = mem_rdata[23:16];
            2'd2: byte_lane = mem_rdata[15:8];
            2'd3: byte_lane = mem_rdata[7:0];
            default: byte_lane = 8'h00;
        endcase
        half_lane = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    end

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = bin4;
        load_data = mem_rdata;
        aligned   = 1'b1;
        case (size)
            SZ_B: begin
                mem_be    = 4'b1000 >> off;
                mem_wdata = {4{bin4[7:0]}};
                load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_H: begin
                mem_be    = off[1] ? 4'b0011 : 4'b1100;
                mem_wdata = {2{bin4[15:0]}};
                load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
                aligned   = ~off[0];
            end
            default: begin
                aligned = (off == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memaccess_sized.sv
// DLX MEM stage with sized big-endian accesses, req/ready stalling, optional wait
// timeout (bus error) and misalignment trap; non-memory ops pass through in one cycle.
module memaccess_sized
    import dlx_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int TIMEOUT       = 0,
    parameter int TRAP_MISALIGN = 1
) (
    input  logic              clock4,
    input  logic              reset4,
    input  logic [31:0]       inst_in4,
    input  logic [31:0]       alu_in4,
    input  logic [31:0]       bin4,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic              stall4,
    output logic [31:0]       inst_out4,
    output logic [31:0]       alu_out4,
    output logic              misalign4,
    output logic              buserr4
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        inst_out_reg, inst_out_next;
    logic [31:0]        alu_out_reg, alu_out_next;
    logic               misalign_reg, misalign_next;
    logic               buserr_reg, buserr_next;
    logic               skip_reg, skip_next;
    logic [31:0]        skip_inst_reg, skip_inst_next;

    mem_op_t            op;
    logic [1:0]         off;
    logic [1:0]         off_eff;
    logic               aligned;
    logic               trap_misalign;
    logic               skip_active;
    logic               timeout_hit;
    logic [3:0]         lane_be;
    logic [31:0]        load_data;

    assign op  = decode_op(inst_in4[31:26]);
    assign off = alu_in4[1:0];

    // Without trapping, the low address bits are forced to the access size's alignment.
    always_comb begin
        off_eff = off;
        if (TRAP_MISALIGN == 0) begin
            case (op.size)
                SZ_H:    off_eff = {off[1], 1'b0};
                SZ_W:    off_eff = 2'b00;
                default: off_eff = off;
            endcase
        end
    end

    mem_lane_align u_lane (
        .size      (op.size),
        .sign_ext  (op.sign_ext),
        .off       (off_eff),
        .bin4      (bin4),
        .mem_rdata (mem_rdata),
        .mem_be    (lane_be),
        .mem_wdata (mem_wdata),
        .load_data (load_data),
        .aligned   (aligned)
    );

    assign trap_misalign = op.is_mem & ~aligned;
    // The post-buserr bubble lasts one cycle and is dropped early if upstream moves on.
    assign skip_active   = skip_reg & (inst_in4 == skip_inst_reg);
    assign timeout_hit   = (TIMEOUT != 0) && (state_reg == ST_WAIT) && (cnt_reg == TIMEOUT_CNT);

    assign mem_req   = op.is_mem & aligned & ~skip_active & ~reset4;
    assign mem_we    = mem_req & ~op.is_load;
    assign mem_addr  = {alu_in4[ADDR_W-1:2], 2'b00};
    assign mem_be    = op.is_mem ? lane_be : 4'b0000;
    assign stall4    = mem_req & ~mem_ready;

    assign inst_out4 = inst_out_reg;
    assign alu_out4  = alu_out_reg;
    assign misalign4 = misalign_reg;
    assign buserr4   = buserr_reg;

    always_ff @(posedge clock4 or posedge reset4) begin
        if (reset4) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            inst_out_reg  <= NOP;
            alu_out_reg   <= 32'h0;
            misalign_reg  <= 1'b0;
            buserr_reg    <= 1'b0;
            skip_reg      <= 1'b0;
            skip_inst_reg <= 32'h0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            inst_out_reg  <= inst_out_next;
            alu_out_reg   <= alu_out_next;
            misalign_reg  <= misalign_next;
            buserr_reg    <= buserr_next;
            skip_reg      <= skip_next;
            skip_inst_reg <= skip_inst_next;
        end
    end

    always_comb begin
        state_next     = ST_IDLE;
        cnt_next       = '0;
        inst_out_next  = inst_out_reg;
        alu_out_next   = alu_out_reg;
        misalign_next  = 1'b0;
        buserr_next    = 1'b0;
        skip_next      = 1'b0;
        skip_inst_next = skip_inst_reg;

        if (!op.is_mem) begin
            inst_out_next = inst_in4;
            alu_out_next  = alu_in4;
        end else if (trap_misalign) begin
            misalign_next = 1'b1;
            inst_out_next = NOP;
            alu_out_next  = alu_in4;
        end else if (skip_active) begin
            inst_out_next = NOP;
        end else if (mem_ready) begin
            // Completion beats a coincident timeout.
            inst_out_next = inst_in4;
            alu_out_next  = op.is_load ? load_data : bin4;
        end else if (timeout_hit) begin
            buserr_next    = 1'b1;
            inst_out_next  = NOP;
            alu_out_next   = alu_in4;
            skip_next      = 1'b1;
            skip_inst_next = inst_in4;
        end else begin
            state_next    = ST_WAIT;
            inst_out_next = NOP;
            if (state_reg == ST_IDLE) begin
                cnt_next = CNT_W'(1);
            end else if (cnt_reg == {CNT_W{1'b1}}) begin
                cnt_next = cnt_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_memaccess_sized.sv
// Directed self-checking bench for memaccess_sized (TIMEOUT=4, misalignment trapped).
module tb_memaccess_sized;

    logic        clock4;
    logic        reset4;
    logic [31:0] inst_in4;
    logic [31:0] alu_in4;
    logic [31:0] bin4;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        stall4;
    logic [31:0] inst_out4;
    logic [31:0] alu_out4;
    logic        misalign4;
    logic        buserr4;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_ADD2 = 32'h0043_2020;
    localparam logic [31:0] I_LB   = {6'b000001, 26'h0000111};
    localparam logic [31:0] I_LBU  = {6'b000010, 26'h0000222};
    localparam logic [31:0] I_SH   = {6'b001001, 26'h0000333};
    localparam logic [31:0] I_LW1  = {6'b000101, 26'h0000444};
    localparam logic [31:0] I_LW2  = {6'b000101, 26'h0000555};
    localparam logic [31:0] I_LW3  = {6'b000101, 26'h0000666};
    localparam logic [31:0] I_LW4  = {6'b000101, 26'h0000777};
    localparam logic [31:0] I_LW5  = {6'b000101, 26'h0000888};

    memaccess_sized #(
        .ADDR_W        (32),
        .TIMEOUT       (4),
        .TRAP_MISALIGN (1)
    ) dut (
        .clock4    (clock4),
        .reset4    (reset4),
        .inst_in4  (inst_in4),
        .alu_in4   (alu_in4),
        .bin4      (bin4),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .stall4    (stall4),
        .inst_out4 (inst_out4),
        .alu_out4  (alu_out4),
        .misalign4 (misalign4),
        .buserr4   (buserr4)
    );

    initial clock4 = 1'b0;
    always #5 clock4 = ~clock4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] b, input logic [31:0] rd, input logic rdy);
        inst_in4  = inst;
        alu_in4   = alu;
        bin4      = b;
        mem_rdata = rd;
        mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clock4);
        #1;
    endtask

    initial begin
        reset4 = 1'b1;
        drive(I_LW1, 32'h100, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        check("rst_inst_out", inst_out4, 32'h0);
        check("rst_alu_out", alu_out4, 32'h0);
        check("rst_misalign", {31'h0, misalign4}, 32'h0);
        check("rst_buserr", {31'h0, buserr4}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_stall", {31'h0, stall4}, 32'h0);
        reset4 = 1'b0;

        // Non-memory pass-through
        drive(I_ADD, 32'h1234, 32'h0, 32'h0, 1'b0);
        check("add_mem_req", {31'h0, mem_req}, 32'h0);
        check("add_stall", {31'h0, stall4}, 32'h0);
        tick();
        $display("txn ADD  inst_out4=%h alu_out4=%h", inst_out4, alu_out4);
        check("add_inst_out", inst_out4, I_ADD);
        check("add_alu_out", alu_out4, 32'h1234);

        // LB at 0x103: lowest lane, sign-extended
        drive(I_LB, 32'h103, 32'h0, 32'h0000_00F0, 1'b1);
        check("lb_mem_req", {31'h0, mem_req}, 32'h1);
        check("lb_mem_we", {31'h0, mem_we}, 32'h0);
        check("lb_mem_be", {28'h0, mem_be}, 32'h1);
        check("lb_mem_addr", mem_addr, 32'h100);
        check("lb_stall", {31'h0, stall4}, 32'h0);
        tick();
        $display("txn LB   inst_out4=%h alu_out4=%h", inst_out4, alu_out4);
        check("lb_alu_out", alu_out4, 32'hFFFF_FFF0);
        check("lb_inst_out", inst_out4, I_LB);

        drive(I_LBU, 32'h103, 32'h0, 32'h0000_00F0, 1'b1);
        tick();
        $display("txn LBU  inst_out4=%h alu_out4=%h", inst_out4, alu_out4);
        check("lbu_alu_out", alu_out4, 32'h0000_00F0);

        // SH at 0x202: low halfword lanes, replicated data
        drive(I_SH, 32'h202, 32'hAAAA_BEEF, 32'h0, 1'b1);
        check("sh_mem_we", {31'h0, mem_we}, 32'h1);
        check("sh_mem_be", {28'h0, mem_be}, 32'h3);
        check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_mem_addr", mem_addr, 32'h200);
        tick();
        $display("txn SH   inst_out4=%h alu_out4=%h", inst_out4, alu_out4);
        check("sh_alu_out", alu_out4, 32'hAAAA_BEEF);
        check("sh_inst_out", inst_out4, I_SH);

        // LW with three unready cycles, then completion
        drive(I_LW1, 32'h300, 32'h0, 32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("lw_stall_wait", {31'h0, stall4}, 32'h1);
            tick();
            check("lw_bubble_inst", inst_out4, 32'h0);
            check("lw_alu_hold", alu_out4, 32'hAAAA_BEEF);
        end
        drive(I_LW1, 32'h300, 32'h0, 32'hCAFE_F00D, 1'b1);
        check("lw_stall_done", {31'h0, stall4}, 32'h0);
        check("lw_req_done", {31'h0, mem_req}, 32'h1);
        tick();
        $display("txn LW   inst_out4=%h alu_out4=%h", inst_out4, alu_out4);
        check("lw_alu_out", alu_out4, 32'hCAFE_F00D);
        check("lw_inst_out", inst_out4, I_LW1);

        // Timeout: issue cycle, then WAIT with counter 1..4; the fourth WAIT cycle trips it
        drive(I_LW2, 32'h400, 32'h0, 32'h5555_6666, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_no_buserr", {31'h0, buserr4}, 32'h0);
        end
        check("to_stall_last", {31'h0, stall4}, 32'h1);
        tick();
        $display("txn TOUT buserr4=%0b inst_out4=%h alu_out4=%h", buserr4, inst_out4, alu_out4);
        check("to_buserr", {31'h0, buserr4}, 32'h1);
        check("to_inst_out", inst_out4, 32'h0);
        check("to_alu_out", alu_out4, 32'h400);
        check("to_skip_req", {31'h0, mem_req}, 32'h0);
        check("to_skip_stall", {31'h0, stall4}, 32'h0);
        tick();
        check("to_buserr_pulse", {31'h0, buserr4}, 32'h0);
        check("to_skip_inst", inst_out4, 32'h0);
        check("to_req_back", {31'h0, mem_req}, 32'h1);
        drive(I_LW2, 32'h400, 32'h0, 32'h5555_6666, 1'b1);
        tick();
        check("to_retry_alu", alu_out4, 32'h5555_6666);

        // Ready on the same cycle the counter reaches TIMEOUT: completion wins
        drive(I_LW3, 32'h500, 32'h0, 32'h1122_3344, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        drive(I_LW3, 32'h500, 32'h0, 32'h1122_3344, 1'b1);
        tick();
        $display("txn SIMU buserr4=%0b inst_out4=%h alu_out4=%h", buserr4, inst_out4, alu_out4);
        check("sim_buserr", {31'h0, buserr4}, 32'h0);
        check("sim_alu_out", alu_out4, 32'h1122_3344);
        check("sim_inst_out", inst_out4, I_LW3);

        // Misaligned word load
        drive(I_LW4, 32'h102, 32'h0, 32'h9999_9999, 1'b1);
        check("mis_mem_req", {31'h0, mem_req}, 32'h0);
        check("mis_stall", {31'h0, stall4}, 32'h0);
        tick();
        $display("txn MIS  misalign4=%0b inst_out4=%h alu_out4=%h", misalign4, inst_out4, alu_out4);
        check("mis_flag", {31'h0, misalign4}, 32'h1);
        check("mis_inst_out", inst_out4, 32'h0);
        check("mis_alu_out", alu_out4, 32'h102);
        drive(I_ADD2, 32'h55, 32'h0, 32'h0, 1'b0);
        tick();
        check("mis_pulse", {31'h0, misalign4}, 32'h0);
        check("add2_alu_out", alu_out4, 32'h55);

        // Reset mid-WAIT
        drive(I_LW5, 32'h600, 32'h0, 32'h0, 1'b0);
        tick();
        check("rw_req_before", {31'h0, mem_req}, 32'h1);
        reset4 = 1'b1;
        #1;
        $display("txn RSTW mem_req=%0b inst_out4=%h alu_out4=%h", mem_req, inst_out4, alu_out4);
        check("rw_mem_req", {31'h0, mem_req}, 32'h0);
        check("rw_stall", {31'h0, stall4}, 32'h0);
        check("rw_inst_out", inst_out4, 32'h0);
        check("rw_alu_out", alu_out4, 32'h0);
        tick();
        reset4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memaccess_sized.md
Name: memaccess_sized

Overview:
- Parametrised successor of the DLX MEM stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Supports byte, halfword and word loads/stores with big-endian lane steering, sign/zero extension and byte enables.
- Supports a variable-latency memory via a req/ready handshake that stalls the pipeline, with an optional wait timeout and a misalignment trap.
- Non-memory instructions pass through in one cycle, as in the previous generation.

Parameters:
- ADDR_W, 32, width of mem_addr (taken from alu_in4[ADDR_W-1:0]); legal range 16..32.
- TIMEOUT, 0, maximum stalled cycles before a bus error; 0 disables the timeout.
- TRAP_MISALIGN, 1, 1 = misaligned access is suppressed and flagged; 0 = low address bits are forced to alignment and the access proceeds.

Ports:
- clock4 in 1: stage clock, rising edge.
- reset4 in 1: asynchronous, active-high reset.
- inst_in4 in 32: IR4; opcode is [31:26].
- alu_in4 in 32: effective address, or ALU result for non-memory instructions.
- bin4 in 32: store data (rt).
- mem_rdata in 32: read data; valid when mem_ready=1.
- mem_ready in 1: memory completes the current request this cycle.
- mem_req out 1: access request.
- mem_we out 1: write strobe, qualified by mem_req.
- mem_addr out ADDR_W: word-aligned address, low 2 bits forced to 0.
- mem_be out 4: byte enables; bit3 = bits [31:24] (byte offset 0, big-endian).
- mem_wdata out 32: lane-replicated store data.
- stall4 out 1: hold IF..EX and keep inst_in4 stable.
- inst_out4 out 32: IR5.
- alu_out4 out 32: load data, or pass-through value.
- misalign4 out 1: one-cycle pulse, registered.
- buserr4 out 1: one-cycle pulse, registered.

Behaviour:
- Opcodes (decided): LB 000001, LBU 000010, LH 000011, LHU 000100, LW 000101, SB 001000, SH 001001, SW 001010. All other opcodes are non-memory.
- Reset (reset4=1, async): inst_out4, alu_out4, misalign4 and buserr4 = 0; FSM = IDLE; wait counter = 0. mem_req, mem_we and stall4 are gated low while reset4=1.
- FSM has two states:
  - IDLE: no outstanding request.
  - WAIT: request outstanding, at least one unready cycle has elapsed.
- Combinational request:
  - mem_req = is_mem & aligned & (state IDLE or WAIT) & ~reset4.
  - mem_addr, mem_be, mem_we and mem_wdata are decoded directly from the current inputs.
- Combinational stall: stall4 = mem_req & ~mem_ready.
- IDLE transitions:
  - Non-memory op: inst_out4 <= inst_in4; alu_out4 <= alu_in4. Latency 1.
  - Memory op with mem_ready=1: completes the same cycle, latency 1.
    - Load: alu_out4 <= extracted and extended data.
    - Store: alu_out4 <= bin4, kept for the WB forwarding path.
    - inst_out4 <= inst_in4.
  - Memory op with mem_ready=0: go to WAIT; counter <= 1; inst_out4 <= 0 (bubble); alu_out4 holds.
- WAIT transitions:
  - mem_ready=1: complete as above; return to IDLE; counter <= 0.
  - mem_ready=0: counter++; bubble.
  - TIMEOUT≠0 and counter==TIMEOUT with mem_ready=0: buserr4 <= 1 for one cycle; inst_out4 <= 0; alu_out4 <= alu_in4; return to IDLE. On the following cycle mem_req is suppressed for one cycle, using an internal "skip" flag cleared when inst_in4 changes or after one cycle. Upstream treats buserr4 as a squash.
- Alignment:
  - Halfword needs addr[0]=0; word needs addr[1:0]=00.
  - TRAP_MISALIGN=1 and misaligned: no mem_req; misalign4 <= 1 pulse; inst_out4 <= 0; alu_out4 <= alu_in4 (bad address). No stall.
- Lane steering, with off = addr[1:0]:
  - Byte: mem_be = 4'b1000 >> off; mem_wdata = {4{bin4[7:0]}}.
  - Halfword: mem_be = off[1] ? 0011 : 1100; mem_wdata = {2{bin4[15:0]}}.
  - Word: mem_be = 1111; mem_wdata = bin4.
  - Loads drive mem_be the same way; mem_we = 0.
- Load extraction:
  - Byte lane = mem_rdata[31-8*off -: 8].
  - Halfword lane = off[1] ? [15:0] : [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word.
- Simultaneous events: mem_ready arriving on the same cycle as counter==TIMEOUT means completion wins and no buserr4.
- Reset mid-WAIT: the request drops immediately (combinationally); no completion is recorded.

Decomposition:
- Package dlx_pkg:
  - opcode localparams (above);
  - mem-size enum {SZ_B, SZ_H, SZ_W};
  - NOP = 32'h0.
- Sub-module mem_lane_align, purely combinational:
  - inputs: size, signed flag, off, bin4, mem_rdata;
  - outputs: mem_be, mem_wdata, load_data, aligned.
- Top holds the FSM, counter and pipeline registers.

Test Plan:
- ADD-class inst, alu_in4=32'h1234 -> next edge inst_out4=inst, alu_out4=32'h1234, mem_req=0, stall4=0.
- LB at addr 0x103, mem_rdata=32'h000000F0, mem_ready=1 -> mem_be=0001, alu_out4=32'hFFFFFFF0. Repeat with LBU -> 32'h000000F0.
- SH at addr 0x202, bin4=32'hAAAABEEF, ready=1 -> mem_we=1, mem_be=0011, mem_wdata=32'hBEEFBEEF, mem_addr=0x200.
- LW with ready low for 3 cycles -> stall4=1 for 3 cycles and inst_out4=0 during them; on cycle 4 alu_out4=mem_rdata and stall4=0.
- TIMEOUT=4, ready never rises -> buserr4 pulses after cycle 4; mem_req low for 1 cycle; inst_out4=0. Separately, with ready asserted on cycle 4 -> completion and no buserr4.
- LW at addr 0x102 -> misalign4 pulse, mem_req never asserted, alu_out4=0x102. Reset asserted mid-WAIT -> mem_req=0 immediately and all outputs 0.
